// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, oversampling ratio and the
// data-bit-count legalisation used by both the transmitter and the receiver.
package uart_pkg;

    // Frame states, common to both directions
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] NBITS_6 = 4'd6;
    localparam logic [3:0] NBITS_7 = 4'd7;
    localparam logic [3:0] NBITS_8 = 4'd8;

    // Any data-bit count other than 6 or 7 falls back to 8
    function automatic logic [3:0] legalize_nbits(input logic [3:0] nbits);
        case (nbits)
            NBITS_6, NBITS_7: return nbits;
            default:          return NBITS_8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rs232_tx.sv
// RS-232 transmitter: start bit, NBits data bits LSB-first, one stop bit.
// Paced by the shared 16x Tick clock-enable; every output is a flop.
module uart_rs232_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_W     = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Tick,
    input  logic              TxEn,
    input  logic              TxStart,
    input  logic [DATA_W-1:0] TxData,
    input  logic [3:0]        NBits,
    output logic              Tx,
    output logic              TxBusy,
    output logic              TxDone
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    uart_state_e       r_state;
    logic [3:0]        r_tick_cnt;
    logic [3:0]        r_bit_cnt;
    logic [3:0]        r_nbits;
    logic [DATA_W-1:0] r_shift;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    logic              w_bit_end;
    logic [3:0]        w_bit_cnt_next;

    // A bit period ends on the 16th Tick counted in the current state
    assign w_bit_end      = Tick && (r_tick_cnt == TICK_LAST);
    assign w_bit_cnt_next = r_bit_cnt + 4'd1;

    // Frame sequencer with registered serial line, busy and done outputs
    // NOTE: every register, including the shift register, has a defined reset
    // value so an aborted frame leaves no stale data behind.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= IDLE;
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= 4'd0;
            r_nbits    <= NBITS_8;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge register values regardless of statement order.
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    // Blocked during the TxDone cycle to guarantee one idle Clk
                    if (TxStart && TxEn && !r_done) begin
                        r_shift    <= TxData;
                        r_nbits    <= legalize_nbits(NBits);
                        r_tick_cnt <= 4'd0;
                        r_bit_cnt  <= 4'd0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (Tick) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                    end
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (Tick) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                    end
                    if (w_bit_end) begin
                        r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
                        r_bit_cnt <= w_bit_cnt_next;
                        if (w_bit_cnt_next == r_nbits) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_tx <= r_shift[1];
                        end
                    end
                end
                STOP: begin
                    if (Tick) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                    end
                    if (w_bit_end) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Tx     = r_tx;
    assign TxBusy = r_busy;
    assign TxDone = r_done;

endmodule

// File: tb/tb_uart_rs232_tx.sv
// Scoreboard bench for uart_rs232_tx: the stimulus queues each accepted frame,
// a monitor decodes the serial line mid-bit and compares against the queue.
module tb_uart_rs232_tx;

    typedef struct {
        logic [7:0] data;
        int         nbits;
        bit         abort;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b1;
    logic       Tick = 1'b0;
    logic       TxEn = 1'b0;
    logic       TxStart = 1'b0;
    logic [7:0] TxData = 8'h00;
    logic [3:0] NBits = 4'd8;
    logic       Tx;
    logic       TxBusy;
    logic       TxDone;

    int   n_compared = 0;
    int   n_mismatched = 0;
    exp_t exp_q[$];
    bit   mon_active = 0;
    bit   tick_fast = 0;

    uart_rs232_tx #(.OVERSAMPLE(16), .DATA_W(8)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Tick    (Tick),
        .TxEn    (TxEn),
        .TxStart (TxStart),
        .TxData  (TxData),
        .NBits   (NBits),
        .Tx      (Tx),
        .TxBusy  (TxBusy),
        .TxDone  (TxDone)
    );

    always #5 Clk = ~Clk;

    // Tick every 4 Clk, or continuously in fast mode; driven just after posedge
    initial begin : tick_gen
        int cnt = 0;
        forever begin
            @(posedge Clk);
            #1;
            cnt++;
            Tick = tick_fast || (cnt % 4 == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode one frame, starting at the first negedge where Tx is low
    task automatic run_frame(input exp_t e);
        int         ticks = 0;
        int         cyc = 0;
        int         k;
        logic [7:0] got = 8'h00;
        logic       start_bit = 1'b1;
        logic       stop_bit = 1'b0;
        bit         aborted = 0;
        bit         timed_out = 0;
        forever begin
            if (!Rst_n) begin aborted = 1; break; end
            if (TxDone) break;
            if (Tick) begin
                ticks++;
                if (ticks >= 8 && (ticks - 8) % 16 == 0) begin
                    k = (ticks - 8) / 16;
                    if (k == 0)                 start_bit = Tx;
                    else if (k <= e.nbits)      got[k-1] = Tx;
                    else if (k == e.nbits + 1)  stop_bit = Tx;
                end
            end
            cyc++;
            if (cyc > 3000) begin timed_out = 1; break; end
            @(negedge Clk);
        end
        if (timed_out) begin
            check("frame_timeout", 32'd1, 32'd0);
        end else if (aborted) begin
            check("abort_expected", 32'(e.abort), 32'd1);
            check("reset_tx_high", 32'(Tx), 32'd1);
        end else begin
            check("abort_not_seen", 32'(e.abort), 32'd0);
            check("start_bit", 32'(start_bit), 32'd0);
            check("data", 32'(got), 32'(e.data) & ((32'd1 << e.nbits) - 32'd1));
            check("stop_bit", 32'(stop_bit), 32'd1);
            check("frame_ticks", 32'(ticks), 32'(16 * (e.nbits + 2)));
            check("busy_falls_with_done", 32'(TxBusy), 32'd0);
            @(negedge Clk);
            check("done_one_cycle", 32'(TxDone), 32'd0);
        end
    endtask

    // Monitor: pops the expected frame whenever the line goes low
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Rst_n && Tx == 1'b0) begin
                mon_active = 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    for (int i = 0; i < 3000 && TxBusy; i++) @(negedge Clk);
                end else begin
                    e = exp_q.pop_front();
                    run_frame(e);
                end
                mon_active = 0;
            end
        end
    end

    // Issue one request from a posedge+1 context; the frame is queued on acceptance
    task automatic send(input logic [7:0] d, input logic [3:0] nb, input int exp_n, input bit abort);
        exp_t e;
        TxData  = d;
        NBits   = nb;
        TxEn    = 1'b1;
        TxStart = 1'b1;
        @(posedge Clk);
        #1;
        TxStart = 1'b0;
        e.data  = d;
        e.nbits = exp_n;
        e.abort = abort;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge Clk);
            #1;
            if (!TxBusy && !mon_active && exp_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) check("wait_idle_timeout", 32'd1, 32'd0);
        repeat (3) @(posedge Clk);
        #1;
    endtask

    initial begin : stimulus
        exp_t e;
        int   gap;
        bit   seen;

        #2 Rst_n = 1'b0;
        #1;
        check("reset_tx", 32'(Tx), 32'd1);
        check("reset_busy", 32'(TxBusy), 32'd0);
        check("reset_done", 32'(TxDone), 32'd0);
        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        check("idle_tx_with_ticks", 32'(Tx), 32'd1);

        // Basic frames at each legal width, plus illegal widths falling back to 8
        send(8'hA5, 4'd8, 8, 0);  wait_idle();
        send(8'hD5, 4'd7, 7, 0);  wait_idle();
        send(8'hFF, 4'd6, 6, 0);  wait_idle();
        send(8'h3C, 4'd4, 8, 0);  wait_idle();
        send(8'h96, 4'd15, 8, 0); wait_idle();

        // Mid-frame TxStart with new data and width is ignored
        send(8'h5A, 4'd8, 8, 0);
        repeat (100) @(posedge Clk);
        #1;
        TxData = 8'h00; NBits = 4'd6; TxStart = 1'b1;
        repeat (2) @(posedge Clk);
        #1 TxStart = 1'b0;
        wait_idle();
        repeat (50) @(posedge Clk);
        #1;

        // TxEn low blocks acceptance
        TxEn = 1'b0; TxData = 8'h11; NBits = 4'd8; TxStart = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        check("txen_blocks", 32'(TxBusy), 32'd0);
        TxStart = 1'b0; TxEn = 1'b1;
        repeat (4) @(posedge Clk);
        #1;

        // TxStart held through TxDone: next frame after exactly one idle Clk
        e.data = 8'h81; e.nbits = 8; e.abort = 0;
        exp_q.push_back(e);
        exp_q.push_back(e);
        TxData = 8'h81; NBits = 4'd8; TxStart = 1'b1;
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (TxDone) begin seen = 1; break; end
        end
        check("b2b_first_done_seen", 32'(seen), 32'd1);
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            gap++;
            if (TxBusy) break;
        end
        check("b2b_restart_gap", 32'(gap), 32'd2);
        @(posedge Clk);
        #1 TxStart = 1'b0;
        wait_idle();

        // Tick held high continuously
        tick_fast = 1;
        send(8'hC3, 4'd8, 8, 0);
        wait_idle();
        tick_fast = 0;

        // Reset during data bit 3 drops the frame immediately
        send(8'hE7, 4'd8, 8, 1);
        repeat (4 * (16 * 4 + 8)) @(posedge Clk);
        #1;
        check("pre_reset_busy", 32'(TxBusy), 32'd1);
        Rst_n = 1'b0;
        #1;
        check("async_reset_tx", 32'(Tx), 32'd1);
        check("async_reset_busy", 32'(TxBusy), 32'd0);
        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b1;
        repeat (200) @(posedge Clk);
        #1;
        check("post_reset_tx", 32'(Tx), 32'd1);
        check("post_reset_busy", 32'(TxBusy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rs232_tx.md
Name: uart_rs232_tx

Overview:
- UART transmitter; the transmit counterpart of the team's RS-232 receiver.
- Serialises a parallel byte as 1 start bit (0), NBits data bits LSB-first, and 1 stop bit (1).
- Shares the receiver's 16x-oversampled Tick and runtime NBits, so one baud generator and one config register drive both directions.
- Fully synchronous to Clk. Tick is a clock-enable, never a clock.

Parameters:
- OVERSAMPLE, 16, number of Tick pulses per serial bit.
- DATA_W, 8, maximum data bits per frame and width of TxData.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  reset; asynchronous, active-low.
- Tick  in  1  single-Clk-cycle pulse at 16x baud rate.
- TxEn  in  1  transmitter enable; gates acceptance of new frames only.
- TxStart  in  1  request to send; sampled on Clk.
- TxData  in  8  byte to send; bits above NBits are ignored.
- NBits  in  4  data bits per frame; legal values 6, 7, 8; any other value is treated as 8.
- Tx  out  1  serial line; idles high.
- TxBusy  out  1  high from acceptance through the end of the stop bit.
- TxDone  out  1  one-Clk-cycle pulse when the stop bit completes.

Behaviour:
- Reset values: Tx=1, TxBusy=0, TxDone=0, state=IDLE, tick counter=0, bit counter=0, shift register=0.
- Async reset mid-frame forces Tx high immediately and drops the frame.
- All outputs are registered.
- States:
  - IDLE: Tx=1. On TxStart & TxEn at a Clk edge:
    - latch TxData into the shift register;
    - latch NBits, after legalisation, into nbits_q;
    - clear the tick and bit counters;
    - go to START.
  - START: Tx=0. Count Tick pulses. On the 16th Tick, go to DATA.
  - DATA: Tx=shift[0]. On every 16th Tick:
    - shift right;
    - increment the bit counter;
    - after nbits_q bits, go to STOP.
  - STOP: Tx=1. On the 16th Tick: pulse TxDone for 1 Clk, go to IDLE.
- Tx changes only on the Clk edge following acceptance or a 16th Tick. No glitches; Tx is driven from a flop.
- Start-bit length: 15 to 16 tick periods, because acceptance is asynchronous to Tick. This is inside the receiver's mid-bit sampling tolerance.
- All other bits are exactly 16 tick periods.
- TxBusy rises the Clk after acceptance and falls together with the TxDone pulse.
- TxStart while TxBusy=1 is ignored; no queuing.
- TxStart in the same cycle TxDone is high is ignored. The earliest next acceptance is the following cycle, so back-to-back frames get a minimum idle of 1 Clk.
- TxData and NBits changes after acceptance have no effect on the current frame.
- TxEn deassertion mid-frame does not truncate the frame; it only blocks the next acceptance.
- Tick held high continuously: each Clk counts as one Tick. This is legal and used for fast simulation.
- Tick asserted in IDLE is ignored; counters stay at 0.
- Counter widths:
  - tick counter 4 bits; wraps 15 to 0 on a bit boundary;
  - bit counter 4 bits; compared against nbits_q with no overflow.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding (IDLE, START, DATA, STOP), common with the receiver;
  - OVERSAMPLE=16;
  - NBITS_6/7/8 constants;
  - the NBits legalisation function, reused by the receiver.
- No sub-module. The baud tick generator lives outside and is shared with the receiver.

Test Plan:
- NBits=8, TxData=0xA5, TxStart pulse, Tick every 4 Clk -> Tx = 0,1,0,1,0,0,1,0,1,1, each 16 Ticks long (start bit 15-16). TxDone pulses once. TxBusy high for the whole frame.
- NBits=7, TxData=0xD5 -> 7 data bits 1,0,1,0,1,0,1 then stop. Bit 7 is never sent. Frame = 9 bits.
- NBits=6, TxData=0xFF -> six 1s then stop. NBits=4 gives the same frame as NBits=8.
- TxStart re-asserted mid-frame with TxData=0x00 -> ignored; the first frame is unchanged. TxStart held through TxDone -> the next frame starts exactly 1 Clk after TxDone.
- Rst_n low during DATA bit 3 -> Tx=1 and TxBusy=0 immediately. After release, no output until a new TxStart.
- Loopback of Tx into the receiver with the same Tick and NBits, random bytes for 8/7/6 -> received byte matches, one RxDone per TxDone.
